// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the external async SRAM controller.
//   - state_e       : controller FSM states
//   - DefAddrW/DataW: default SRAM word-address and data widths
//   - MaxWaitStates : largest supported WAIT_STATES value
//   - cnt_width()   : wait-counter width for a given WAIT_STATES
package sram_pkg;

    localparam int unsigned DefAddrW      = 18;
    localparam int unsigned DefDataW      = 16;
    localparam int unsigned MaxWaitStates = 7;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StHold,
        StTurn
    } state_e;

    // max(1, clog2(ws+1)): the counter must hold WAIT_STATES itself.
    function automatic int unsigned cnt_width(input int unsigned ws);
        return (ws < 1) ? 1 : $clog2(ws + 1);
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-word request master for an external asynchronous 16-bit SRAM.
// Sequences CS/OE/WE, drives the data-pin direction and write data, and samples
// read data at the end of the access phase. All pin-side outputs are registered.
//
// Optional feature macro: SRAM_CTRL_TURNAROUND_EN
//   defined   -> a one-cycle bus-idle TURN state follows every read
//   undefined -> reads return straight to IDLE
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     request handshake
//   req_we/addr/wdata       request attributes (1 = write)
//   rsp_valid               one-cycle completion pulse (reads and writes)
//   rsp_rdata               last read data, held until the next read completes
//   sram_addr/csn/oen/wen   SRAM address and active-low strobes
//   sram_dir                data-pin output enable (1 = FPGA drives)
//   sram_dout/sram_din      data to / from the pin buffers
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_csn,
    output logic              sram_oen,
    output logic              sram_wen,
    output logic              sram_dir,
    output logic [DATA_W-1:0] sram_dout,
    input  logic [DATA_W-1:0] sram_din
);

    localparam int unsigned CntW = cnt_width(WAIT_STATES);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              csn_q, csn_d;
    logic              oen_q, oen_d;
    logic              wen_q, wen_d;
    logic              dir_q, dir_d;
    logic              busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            csn_q       <= 1'b1;
            oen_q       <= 1'b1;
            wen_q       <= 1'b1;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            csn_q       <= csn_d;
            oen_q       <= oen_d;
            wen_q       <= wen_d;
            dir_q       <= dir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CntW'(WAIT_STATES);
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        state_d = StHold;
                    end else begin
                        // Sample at the last access edge; the SRAM has had
                        // WAIT_STATES+1 cycles to drive valid data.
                        rdata_d     = sram_din;
                        rsp_valid_d = 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
                        state_d     = StTurn;
`else
                        state_d     = StIdle;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StHold: begin
                rsp_valid_d = 1'b1;
                state_d     = StIdle;
            end
`ifdef SRAM_CTRL_TURNAROUND_EN
            StTurn: begin
                state_d = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        // Pin strobes are registered from the next state so they change only
        // on clock edges and line up with the state they belong to.
        busy_d = (state_d == StAccess) || (state_d == StHold);
        csn_d  = ~busy_d;
        oen_d  = ~((state_d == StAccess) && !we_d);
        wen_d  = ~((state_d == StAccess) && we_d);
        // HOLD keeps the data driven after WE rises; reads never drive.
        dir_d  = busy_d && we_d;
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign sram_addr = addr_q;
    assign sram_csn  = csn_q;
    assign sram_oen  = oen_q;
    assign sram_wen  = wen_q;
    assign sram_dir  = dir_q;
    assign sram_dout = wdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: self-checking bench for sram_ctrl.
// Main instance uses WAIT_STATES=1 and is checked every cycle against a
// timeline model (access/hold/response windows computed from the accept cycle).
// A second instance with WAIT_STATES=0 gets a short directed read.
module tb_sram_ctrl;

    localparam int WS = 1;
`ifdef SRAM_CTRL_TURNAROUND_EN
    localparam int TurnExtra = 1;
    localparam int B2bSpacing = 4;
`else
    localparam int TurnExtra = 0;
    localparam int B2bSpacing = 3;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [17:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [17:0] sram_addr;
    logic        sram_csn;
    logic        sram_oen;
    logic        sram_wen;
    logic        sram_dir;
    logic [15:0] sram_dout;
    logic [15:0] sram_din;

    logic        r0_valid;
    logic        r0_ready;
    logic        r0_we;
    logic [17:0] r0_addr;
    logic [15:0] r0_wdata;
    logic        r0_rsp_valid;
    logic [15:0] r0_rdata;
    logic [17:0] r0_sram_addr;
    logic        r0_csn;
    logic        r0_oen;
    logic        r0_wen;
    logic        r0_dir;
    logic [15:0] r0_dout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    sram_ctrl #(
        .ADDR_W     (18),
        .DATA_W     (16),
        .WAIT_STATES(WS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .sram_addr(sram_addr),
        .sram_csn (sram_csn),
        .sram_oen (sram_oen),
        .sram_wen (sram_wen),
        .sram_dir (sram_dir),
        .sram_dout(sram_dout),
        .sram_din (sram_din)
    );

    sram_ctrl #(
        .ADDR_W     (18),
        .DATA_W     (16),
        .WAIT_STATES(0)
    ) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(r0_valid),
        .req_ready(r0_ready),
        .req_we   (r0_we),
        .req_addr (r0_addr),
        .req_wdata(r0_wdata),
        .rsp_valid(r0_rsp_valid),
        .rsp_rdata(r0_rdata),
        .sram_addr(r0_sram_addr),
        .sram_csn (r0_csn),
        .sram_oen (r0_oen),
        .sram_wen (r0_wen),
        .sram_dir (r0_dir),
        .sram_dout(r0_dout),
        .sram_din (16'h0A0A)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // SRAM device: 256-word array indexed by the low address byte.
    logic [15:0] env_mem [256];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= 16'hC000 | 16'(i);
        end else if (!sram_csn && !sram_wen) begin
            env_mem[sram_addr[7:0]] <= sram_dout;
        end
    end
    assign sram_din = (!sram_csn && !sram_oen) ? env_mem[sram_addr[7:0]] : 16'hDEAD;

    // Timeline model: windows are absolute cycle numbers derived from the accept cycle.
    logic [15:0] model_mem [256];
    logic        m_we;
    logic [17:0] m_addr;
    logic [15:0] m_data;
    logic [15:0] m_rdata;
    int          m_acc_s, m_acc_e, m_hold, m_rsp, m_free;

    wire         e_in_acc = (cyc >= m_acc_s) && (cyc <= m_acc_e);
    wire         e_in_hold = (cyc == m_hold);
    wire         e_csn = !(e_in_acc || e_in_hold);
    wire         e_oen = !(e_in_acc && !m_we);
    wire         e_wen = !(e_in_acc && m_we);
    wire         e_dir = (e_in_acc || e_in_hold) && m_we;
    wire         e_rsp = (cyc == m_rsp);
    wire         e_ready = (cyc >= m_free);
    wire [15:0]  e_rdata = (e_rsp && !m_we) ? model_mem[m_addr[7:0]] : m_rdata;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) model_mem[i] <= 16'hC000 | 16'(i);
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
            m_rdata <= '0;
            m_acc_s <= -100;
            m_acc_e <= -100;
            m_hold  <= -100;
            m_rsp   <= -100;
            m_free  <= 0;
        end else begin
            chk("csn", sram_csn, e_csn);
            chk("oen", sram_oen, e_oen);
            chk("wen", sram_wen, e_wen);
            chk("dir", sram_dir, e_dir);
            chk("rsp_valid", rsp_valid, e_rsp);
            chk("rsp_rdata", rsp_rdata, e_rdata);
            chk("req_ready", req_ready, e_ready);
            chk("dir_oen_excl", sram_dir && !sram_oen, 1'b0);
            if (!e_csn) chk("sram_addr", sram_addr, m_addr);
            if (e_dir) chk("sram_dout", sram_dout, m_data);
            m_rdata <= e_rdata;
            if (e_ready && req_valid) begin
                m_we    <= req_we;
                m_addr  <= req_addr;
                m_data  <= req_wdata;
                m_acc_s <= cyc + 1;
                m_acc_e <= cyc + 1 + WS;
                if (req_we) begin
                    m_hold <= cyc + 2 + WS;
                    m_rsp  <= cyc + 3 + WS;
                    m_free <= cyc + 3 + WS;
                    model_mem[req_addr[7:0]] <= req_wdata;
                end else begin
                    m_hold <= -100;
                    m_rsp  <= cyc + 2 + WS;
                    m_free <= cyc + 2 + WS + TurnExtra;
                end
            end
        end
    end

    task automatic wait_acc(output int acc);
        acc = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic req(input logic we, input logic [17:0] a, input logic [15:0] d,
                       output int acc);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        wait_acc(acc);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Bit k = value in cycle acc+k; bit 0 is the idle value of the accept cycle.
    task automatic cap(output logic [5:0] wen_v, output logic [5:0] oen_v,
                       output logic [5:0] dir_v, output logic [5:0] rsp_v);
        wen_v = 6'b000001;
        oen_v = 6'b000001;
        dir_v = 6'b000000;
        rsp_v = 6'b000000;
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            wen_v[k] = sram_wen;
            oen_v[k] = sram_oen;
            dir_v[k] = sram_dir;
            rsp_v[k] = rsp_valid;
        end
    endtask

    initial begin
        int          a1, a2;
        logic [5:0]  wv, ov, dv, rv;
        logic [4:0]  o0, r0;
        int          got;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        r0_valid  = 1'b0;
        r0_we     = 1'b0;
        r0_addr   = '0;
        r0_wdata  = '0;

        #12;
        chk("rst_csn", sram_csn, 1'b1);
        chk("rst_oen", sram_oen, 1'b1);
        chk("rst_wen", sram_wen, 1'b1);
        chk("rst_dir", sram_dir, 1'b0);
        chk("rst_addr", sram_addr, 18'h0);
        chk("rst_dout", sram_dout, 16'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rdata", rsp_rdata, 16'h0);
        chk("rst_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Write 0x00123 <- 0xBEEF
        req(1'b1, 18'h00123, 16'hBEEF, a1);
        cap(wv, ov, dv, rv);
        chk("wr_wen_window", wv, 6'b111001);
        chk("wr_dir_window", dv, 6'b001110);
        chk("wr_rsp_cycle", rv, 6'b010000);
        chk("wr_oen_idle", ov, 6'b111111);

        // Read it back
        req(1'b0, 18'h00123, 16'h0000, a1);
        cap(wv, ov, dv, rv);
        chk("rd_oen_window", ov, 6'b111001);
        chk("rd_rsp_cycle", rv, 6'b001000);
        chk("rd_dir_never", dv, 6'b000000);
        chk("rd_data", rsp_rdata, 16'hBEEF);

        // Back-to-back: read held into a write
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 18'h00055;
        wait_acc(a1);
        @(posedge clk);
        #1;
        req_we    = 1'b1;
        req_addr  = 18'h000AA;
        req_wdata = 16'h1357;
        wait_acc(a2);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_spacing", 32'(a2 - a1), 32'(B2bSpacing));
        chk("b2b_rd_data", rsp_rdata, 16'hC055);
        repeat (5) @(posedge clk);

        // Busy drop: write 0x77, then keep a request up with a moving address
        req(1'b1, 18'h00077, 16'h2468, a1);
        req_valid = 1'b1;
        req_addr  = 18'h00080;
        req_wdata = 16'h2469;
        got = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) begin
                got = cyc;
                break;
            end
            @(posedge clk);
            #1;
            req_addr  = req_addr + 18'd1;
            req_wdata = req_wdata + 16'd1;
        end
        if (got < 0) chk("busy_accept_timeout", 1'b0, 1'b1);
        chk("busy_accept_delay", 32'(got - a1), 32'd4);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("busy_latched_addr", sram_addr, 18'h00083);
        repeat (4) @(posedge clk);
        req(1'b0, 18'h00077, 16'h0000, a1);
        repeat (4) @(posedge clk);
        chk("busy_rd_first", rsp_rdata, 16'h2468);
        req(1'b0, 18'h00083, 16'h0000, a1);
        repeat (4) @(posedge clk);
        chk("busy_rd_second", rsp_rdata, 16'h246C);
        req(1'b0, 18'h000AA, 16'h0000, a1);
        repeat (4) @(posedge clk);
        chk("b2b_wr_readback", rsp_rdata, 16'h1357);

        // WAIT_STATES=0 instance: single read
        @(posedge clk);
        #1;
        r0_valid = 1'b1;
        r0_addr  = 18'h00005;
        @(negedge clk);
        chk("ws0_ready", r0_ready, 1'b1);
        @(posedge clk);
        #1;
        r0_valid = 1'b0;
        o0 = 5'b00001;
        r0 = 5'b00000;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            o0[k] = r0_oen;
            r0[k] = r0_rsp_valid;
        end
        chk("ws0_oen_window", o0, 5'b11101);
        chk("ws0_rsp_cycle", r0, 5'b00100);
        chk("ws0_rdata", r0_rdata, 16'h0A0A);

        // Reset during a write access
        req(1'b1, 18'h30001, 16'h1111, a1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_csn", sram_csn, 1'b1);
        chk("midrst_wen", sram_wen, 1'b1);
        chk("midrst_oen", sram_oen, 1'b1);
        chk("midrst_dir", sram_dir, 1'b0);
        chk("midrst_rsp", rsp_valid, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_ready", req_ready, 1'b1);

        // Recovery read
        req(1'b0, 18'h00123, 16'h0000, a1);
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Logic-side master for the external asynchronous 16-bit SRAM on the Hack FPGA board. Accepts single-word read/write requests from the CPU/memory-map side and sequences the SRAM control strobes. It drives the tristate direction and write data of the bidirectional data pins, and samples their read data. The pins themselves are driven by per-bit bidirectional I/O buffers at board top level.

## Interface
- `ADDR_W`, 18: SRAM word address width.
- `DATA_W`, 16: data bus width.
- `WAIT_STATES`, 1: extra cycles the access phase is held. Legal range 0..7.

- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle completion pulse, for reads and writes.
- `rsp_rdata`  out  DATA_W  read data, held until the next read completes.
- `sram_addr`  out  ADDR_W  address pins.
- `sram_csn`  out  1  chip select, active low.
- `sram_oen`  out  1  output enable, active low.
- `sram_wen`  out  1  write enable, active low.
- `sram_dir`  out  1  pin output-enable (1 = FPGA drives), fanned out to all data-bit buffers.
- `sram_dout`  out  DATA_W  data driven onto the pins.
- `sram_din`  in  DATA_W  data read back from the pins.

## Operation
- FSM states: IDLE, ACCESS, HOLD, TURN.
- **Reset values** (async, immediate): state IDLE, `sram_csn`/`sram_oen`/`sram_wen` = 1, `sram_dir` = 0, `sram_addr` = 0, `sram_dout` = 0, `rsp_valid` = 0, `rsp_rdata` = 0.
- **Reset mid-access**: releases the bus the same instant. The request is lost and no `rsp_valid` is issued.
- **IDLE**
  - `req_ready` = 1; all strobes high; `sram_dir` = 0.
  - On `req_valid`, register `req_we`/`req_addr`/`req_wdata`, load the wait counter with WAIT_STATES, and go to ACCESS.
- **ACCESS**
  - `sram_csn` = 0 and `sram_addr` = latched address.
  - Read: `sram_oen` = 0, `sram_dir` = 0.
  - Write: `sram_wen` = 0, `sram_dir` = 1, `sram_dout` = latched data.
  - The counter decrements each cycle; at 0, the state exits.
  - Read exit: `rsp_rdata` <= `sram_din`, `rsp_valid` <= 1, then go to TURN if `SRAM_CTRL_TURNAROUND_EN`, else IDLE.
  - Write exit: go to HOLD.
- **HOLD** (write only)
  - `sram_wen` = 1, while `sram_csn` = 0, `sram_dir` = 1 and the data stay stable. This gives data hold after the WE rising edge.
  - Set `rsp_valid` <= 1 and go to IDLE.
- **TURN**: `sram_csn` = 1, `sram_oen` = 1, `sram_dir` = 0 for one cycle, then IDLE.
- `req_ready` is 0 outside IDLE. A `req_valid` seen while busy is ignored; the requester holds it.
- `sram_dir` and `sram_oen` are never both active (driven/low) in the same cycle.
- Counter width is max(1, $clog2(WAIT_STATES+1)). There is no wrap: the counter is loaded only in IDLE.

## Timing
- All outputs are registered; strobes change only on `clk` rising edges.
- Accept happens at the edge ending cycle 0.
  - Read: ACCESS occupies cycles 1..1+WAIT_STATES; `rsp_valid` is high in cycle 2+WAIT_STATES.
  - Write: HOLD is in cycle 2+WAIT_STATES; `rsp_valid` is high in cycle 3+WAIT_STATES.
- Back-to-back requests: the next accept can happen in the same cycle as `rsp_valid`. TURN delays it by one cycle after reads.
- `sram_din` is sampled at the last ACCESS edge. The SRAM output must be valid within (WAIT_STATES+1) clock periods minus the pad delay.

## Configuration
- `SRAM_CTRL_TURNAROUND_EN` defined:
  - TURN is compiled in; every read is followed by one bus-idle cycle.
  - Read-to-next-accept spacing is WAIT_STATES+3 cycles.
- `SRAM_CTRL_TURNAROUND_EN` undefined:
  - TURN is absent; reads return directly to IDLE, so spacing is WAIT_STATES+2 cycles.
  - Read `rsp_valid` timing is identical in both builds.

## Structure
- Package `sram_pkg`: state enum (IDLE, ACCESS, HOLD, TURN), default widths (ADDR_W=18, DATA_W=16), and the maximum WAIT_STATES constant.
- No sub-module inside `sram_ctrl`.
- Natural companion: `sram_phy`, instantiated at board top. It bundles DATA_W bidirectional I/O buffer instances sharing `sram_dir`, and connects `sram_dout`/`sram_din`.

## Test plan
- **Reset**: assert `rst_n`=0 mid-write (during ACCESS) → same cycle `sram_dir`=0, all strobes=1; no `rsp_valid` after release; `req_ready`=1.
- **Write/read, WAIT_STATES=1**:
  - Write addr 0x00123 data 0xBEEF → `sram_wen` low cycles 1–2, `sram_dir` high cycles 1–3, `rsp_valid` in cycle 4.
  - Read 0x00123 → `rsp_rdata`=0xBEEF with `rsp_valid` in cycle 3.
- **WAIT_STATES=0**: read → `sram_oen` low exactly 1 cycle, `rsp_valid` in cycle 2.
- **Back-to-back, with macro**: hold `req_valid` for read, then write → write accepted 4 cycles after the read accept; no cycle with `sram_dir`=1 and `sram_oen`=0.
- **Busy drop**: toggle `req_addr` while `req_ready`=0 → latched address unchanged on `sram_addr`; a single `rsp_valid` per accepted request.
